// File: rtl/alu_control_seq.sv
// ALU control decoder with valid/ready handshakes and multi-cycle op timing.
// Ports: clk, rst_n (sync, active-low); in_valid/in_ready, alu_op, opcode
// (request side); out_valid/out_ready, alu_cnt, multi, illegal (result
// side); err_clr, err_count (saturating count of accepted illegal requests).
module alu_control_seq #(
    parameter int AOP_W = 2,
    parameter int OPC_W = 4,
    parameter int CNT_W = 3,
    parameter logic [(1<<CNT_W)-1:0] MULTI_MASK = 8'b1100_0000,
    parameter int MULTI_LAT = 4,
    parameter int ERR_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [AOP_W-1:0] alu_op,
    input  logic [OPC_W-1:0] opcode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [CNT_W-1:0] alu_cnt,
    output logic             multi,
    output logic             illegal,
    input  logic             err_clr,
    output logic [ERR_W-1:0] err_count
);

    localparam int WC_W = 4;
    localparam logic [WC_W-1:0] WC_LOAD = WC_W'(MULTI_LAT - 2);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_HOLD
    } state_e;

    state_e           state_q, state_d;
    logic [WC_W-1:0]  wcnt_q, wcnt_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             multi_q, multi_d;
    logic             ill_q, ill_d;
    logic [ERR_W-1:0] err_q, err_d;

    logic [CNT_W-1:0] dec_cnt;
    logic             dec_ill;
    logic             dec_multi;
    logic             aop_rr, aop_ld, aop_br;
    logic             opc_hi_zero;
    logic             xfer_in;
    logic             xfer_out;

    // Register-register ops need the upper opcode bits clear to be legal.
    assign opc_hi_zero = ((opcode >> 4) == '0);
    assign aop_ld = (alu_op == AOP_W'(2));
    assign aop_br = (alu_op == AOP_W'(1));
    assign aop_rr = (alu_op == '0) && opc_hi_zero;

    always_comb begin
        dec_cnt = '0;
        dec_ill = 1'b0;
        unique case (1'b1)
            aop_ld: dec_cnt = CNT_W'(3'd0);
            aop_br: dec_cnt = CNT_W'(3'd1);
            aop_rr: begin
                unique case (opcode[3:0])
                    4'd3:    dec_cnt = CNT_W'(3'd0);
                    4'd4:    dec_cnt = CNT_W'(3'd1);
                    4'd5:    dec_cnt = CNT_W'(3'd3);
                    4'd6:    dec_cnt = CNT_W'(3'd4);
                    4'd7:    dec_cnt = CNT_W'(3'd5);
                    4'd8:    dec_cnt = CNT_W'(3'd6);
                    4'd9:    dec_cnt = CNT_W'(3'd7);
                    4'd13:   dec_cnt = CNT_W'(3'd1);
                    default: dec_ill = 1'b1;
                endcase
            end
            default: dec_ill = 1'b1;
        endcase
    end

    assign dec_multi = !dec_ill && MULTI_MASK[dec_cnt];

    assign in_ready  = (state_q == S_IDLE) ||
                       ((state_q == S_HOLD) && out_ready);
    assign out_valid = (state_q == S_HOLD);
    assign xfer_in   = in_valid && in_ready;
    assign xfer_out  = out_valid && out_ready;

    always_comb begin
        state_d = state_q;
        wcnt_d  = wcnt_q;
        cnt_d   = cnt_q;
        multi_d = multi_q;
        ill_d   = ill_q;
        err_d   = err_q;

        unique case (state_q)
            S_IDLE: ;
            S_WAIT: begin
                // Leave WAIT on the edge where the counter already reads 0.
                if (wcnt_q == '0) begin
                    state_d = S_HOLD;
                end else begin
                    wcnt_d = wcnt_q - 1'b1;
                end
            end
            S_HOLD: begin
                if (xfer_out) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // A new acceptance overrides the HOLD->IDLE move (back-to-back).
        if (xfer_in) begin
            cnt_d   = dec_cnt;
            multi_d = dec_multi;
            ill_d   = dec_ill;
            if (dec_multi) begin
                state_d = S_WAIT;
                wcnt_d  = WC_LOAD;
            end else begin
                state_d = S_HOLD;
            end
        end

        if (err_clr) begin
            err_d = '0;
        end else if (xfer_in && dec_ill && !(&err_q)) begin
            err_d = err_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            wcnt_q  <= '0;
            cnt_q   <= '0;
            multi_q <= 1'b0;
            ill_q   <= 1'b0;
            err_q   <= '0;
        end else begin
            state_q <= state_d;
            wcnt_q  <= wcnt_d;
            cnt_q   <= cnt_d;
            multi_q <= multi_d;
            ill_q   <= ill_d;
            err_q   <= err_d;
        end
    end

    assign alu_cnt   = cnt_q;
    assign multi     = multi_q;
    assign illegal   = ill_q;
    assign err_count = err_q;

endmodule

// File: tb/tb_alu_control_seq.sv
// Bench for alu_control_seq: decode table, hand-written handshake
// sequences and randomized traffic against a transaction-level model.
module tb_alu_control_seq;

    localparam int LAT = 4;
    localparam logic [7:0] MASK = 8'b1100_0000;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [1:0] alu_op;
    logic [3:0] opcode;
    logic       out_valid;
    logic       out_ready;
    logic [2:0] alu_cnt;
    logic       multi;
    logic       illegal;
    logic       err_clr;
    logic [7:0] err_count;

    alu_control_seq dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .alu_op    (alu_op),
        .opcode    (opcode),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .alu_cnt   (alu_cnt),
        .multi     (multi),
        .illegal   (illegal),
        .err_clr   (err_clr),
        .err_count (err_count)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Model: one pending result, visible from cycle m_rdy on.
    int       m_cyc = 0;
    bit       m_pend = 0;
    int       m_rdy = 0;
    bit [2:0] m_cnt;
    bit       m_multi;
    bit       m_ill;
    int       m_err = 0;

    logic       s_ir, s_ov, s_m, s_il;
    logic [2:0] s_cnt;
    logic [7:0] s_err;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)",
                     nm, act, exp, $time);
        end
    endtask

    // Reference decode straight from the encoding table.
    function automatic void ref_dec(input bit [1:0] a, input bit [3:0] o,
                                    output bit [2:0] c, output bit m,
                                    output bit il);
        int tbl [16];
        for (int i = 0; i < 16; i++) tbl[i] = -1;
        tbl[3] = 0; tbl[4] = 1; tbl[5] = 3; tbl[6] = 4;
        tbl[7] = 5; tbl[8] = 6; tbl[9] = 7; tbl[13] = 1;
        c = 0;
        il = 0;
        if (a == 2) c = 0;
        else if (a == 1) c = 1;
        else if (a == 0 && tbl[o] >= 0) c = 3'(tbl[o]);
        else il = 1;
        m = !il && MASK[c];
    endfunction

    task automatic tick();
        bit e_ir, e_ov, acc;
        bit [2:0] c;
        bit m, il;
        @(negedge clk);
        s_ir  = in_ready;
        s_ov  = out_valid;
        s_cnt = alu_cnt;
        s_m   = multi;
        s_il  = illegal;
        s_err = err_count;
        e_ov = m_pend && (m_cyc >= m_rdy);
        e_ir = !m_pend ? 1'b1 : (e_ov ? out_ready : 1'b0);
        chk("in_ready", 32'(s_ir), 32'(e_ir));
        chk("out_valid", 32'(s_ov), 32'(e_ov));
        if (e_ov) begin
            chk("alu_cnt", 32'(s_cnt), 32'(m_cnt));
            chk("multi", 32'(s_m), 32'(m_multi));
            chk("illegal", 32'(s_il), 32'(m_ill));
        end
        chk("err_count", 32'(s_err), 32'(m_err));
        if (!rst_n) begin
            m_pend = 0;
            m_err  = 0;
        end else begin
            acc = in_valid && e_ir;
            if (e_ov && out_ready) m_pend = 0;
            ref_dec(alu_op, opcode, c, m, il);
            if (acc) begin
                m_pend  = 1;
                m_cnt   = c;
                m_multi = m;
                m_ill   = il;
                m_rdy   = m_cyc + (m ? LAT : 1);
            end
            if (err_clr) m_err = 0;
            else if (acc && il && m_err < 255) m_err++;
        end
        m_cyc++;
        @(posedge clk);
        #1;
    endtask

    task automatic req(input bit v, input bit [1:0] a, input bit [3:0] o);
        in_valid = v;
        alu_op   = a;
        opcode   = o;
    endtask

    typedef struct {
        bit [1:0] a;
        bit [3:0] o;
        bit [2:0] cnt;
        bit       m;
        bit       il;
    } vec_t;

    vec_t vecs [16];

    initial begin
        int  waited;
        bool_loop: begin end
        vecs[0]  = '{2'd2, 4'd0,  3'd0, 1'b0, 1'b0};
        vecs[1]  = '{2'd2, 4'd11, 3'd0, 1'b0, 1'b0};
        vecs[2]  = '{2'd1, 4'd15, 3'd1, 1'b0, 1'b0};
        vecs[3]  = '{2'd0, 4'd3,  3'd0, 1'b0, 1'b0};
        vecs[4]  = '{2'd0, 4'd4,  3'd1, 1'b0, 1'b0};
        vecs[5]  = '{2'd0, 4'd5,  3'd3, 1'b0, 1'b0};
        vecs[6]  = '{2'd0, 4'd6,  3'd4, 1'b0, 1'b0};
        vecs[7]  = '{2'd0, 4'd7,  3'd5, 1'b0, 1'b0};
        vecs[8]  = '{2'd0, 4'd8,  3'd6, 1'b1, 1'b0};
        vecs[9]  = '{2'd0, 4'd9,  3'd7, 1'b1, 1'b0};
        vecs[10] = '{2'd0, 4'd13, 3'd1, 1'b0, 1'b0};
        vecs[11] = '{2'd0, 4'd0,  3'd0, 1'b0, 1'b1};
        vecs[12] = '{2'd0, 4'd2,  3'd0, 1'b0, 1'b1};
        vecs[13] = '{2'd0, 4'd10, 3'd0, 1'b0, 1'b1};
        vecs[14] = '{2'd0, 4'd15, 3'd0, 1'b0, 1'b1};
        vecs[15] = '{2'd3, 4'd5,  3'd0, 1'b0, 1'b1};

        rst_n = 0;
        req(0, 0, 0);
        out_ready = 1;
        err_clr = 0;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        rst_n = 1;

        // Reset state
        tick();
        chk("rst_in_ready", 32'(s_ir), 1);
        chk("rst_out_valid", 32'(s_ov), 0);
        chk("rst_alu_cnt", 32'(s_cnt), 0);
        chk("rst_multi", 32'(s_m), 0);
        chk("rst_illegal", 32'(s_il), 0);
        chk("rst_err", 32'(s_err), 0);

        // Decode table
        for (int i = 0; i < 16; i++) begin
            out_ready = 1;
            req(1, vecs[i].a, vecs[i].o);
            tick();
            req(0, 0, 0);
            waited = 0;
            do begin
                tick();
                waited++;
            end while (!s_ov && waited < 20);
            chk($sformatf("vec%0d_valid", i), 32'(s_ov), 1);
            chk($sformatf("vec%0d_cnt", i), 32'(s_cnt), 32'(vecs[i].cnt));
            chk($sformatf("vec%0d_multi", i), 32'(s_m), 32'(vecs[i].m));
            chk($sformatf("vec%0d_ill", i), 32'(s_il), 32'(vecs[i].il));
            chk($sformatf("vec%0d_lat", i), waited, vecs[i].m ? LAT : 1);
        end

        // Single-cycle result one cycle after acceptance
        req(1, 0, 5);
        tick();
        req(0, 0, 0);
        tick();
        chk("op011_valid", 32'(s_ov), 1);
        chk("op011_cnt", 32'(s_cnt), 3);

        // Multi-cycle: in_ready low throughout WAIT, valid after LAT
        req(1, 0, 8);
        tick();
        req(1, 2, 0);
        for (int k = 1; k < LAT; k++) begin
            tick();
            chk("wait_in_ready", 32'(s_ir), 0);
            chk("wait_out_valid", 32'(s_ov), 0);
        end
        req(0, 0, 0);
        tick();
        chk("mul_valid", 32'(s_ov), 1);
        chk("mul_cnt", 32'(s_cnt), 6);
        chk("mul_multi", 32'(s_m), 1);

        // Back-to-back stream 10,01,10
        req(1, 2, 0);
        tick();
        chk("str0_ir", 32'(s_ir), 1);
        req(1, 1, 0);
        tick();
        chk("str1_ir", 32'(s_ir), 1);
        chk("str1_cnt", 32'(s_cnt), 0);
        chk("str1_ov", 32'(s_ov), 1);
        req(1, 2, 0);
        tick();
        chk("str2_ir", 32'(s_ir), 1);
        chk("str2_cnt", 32'(s_cnt), 1);
        chk("str2_ov", 32'(s_ov), 1);
        req(0, 0, 0);
        tick();
        chk("str3_cnt", 32'(s_cnt), 0);
        chk("str3_ov", 32'(s_ov), 1);
        tick();
        chk("str4_ov", 32'(s_ov), 0);

        // Hold result 101 under backpressure
        req(1, 0, 7);
        tick();
        req(1, 2, 0);
        out_ready = 0;
        for (int k = 0; k < 6; k++) begin
            tick();
            chk("hold_ov", 32'(s_ov), 1);
            chk("hold_cnt", 32'(s_cnt), 5);
            chk("hold_ir", 32'(s_ir), 0);
        end
        req(0, 0, 0);
        out_ready = 1;
        tick();
        chk("hold_rel_ov", 32'(s_ov), 1);
        tick();
        chk("hold_idle_ov", 32'(s_ov), 0);
        chk("hold_idle_ir", 32'(s_ir), 1);

        // Error counter saturation and clear-wins
        err_clr = 1;
        tick();
        err_clr = 0;
        req(1, 3, 0);
        for (int k = 0; k < 256; k++) tick();
        tick();
        chk("err_sat", 32'(s_err), 255);
        tick();
        chk("err_held", 32'(s_err), 255);
        err_clr = 1;
        tick();
        err_clr = 0;
        req(0, 0, 0);
        tick();
        chk("err_clr_wins", 32'(s_err), 0);
        tick();

        // Reset during WAIT aborts the op
        req(1, 0, 8);
        tick();
        req(0, 0, 0);
        tick();
        rst_n = 0;
        tick();
        rst_n = 1;
        for (int k = 0; k < LAT + 2; k++) begin
            tick();
            chk("abort_ov", 32'(s_ov), 0);
            chk("abort_ir", 32'(s_ir), 1);
            chk("abort_cnt", 32'(s_cnt), 0);
            chk("abort_multi", 32'(s_m), 0);
            chk("abort_ill", 32'(s_il), 0);
        end

        // Randomized traffic against the model
        for (int k = 0; k < 3000; k++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            alu_op    = 2'($urandom_range(0, 3));
            opcode    = 4'($urandom_range(0, 15));
            out_ready = ($urandom_range(0, 3) != 0);
            err_clr   = ($urandom_range(0, 63) == 0);
            rst_n     = ($urandom_range(0, 299) != 0);
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation time limit reached");
        $fatal(1);
    end

endmodule
